ram_port_ctrl: RTL
==================

Name: ram_port_ctrl

Overview:
- Requester-side controller for one port of the team's dual-port RAM.
- Accepts byte-strobed read/write requests on a valid/ready interface and drives the RAM port (en/addr/strobe/wdata).
- Tracks the fixed RAM read latency and returns exactly one in-order response per request on a valid/ready response channel.
- Absorbs response backpressure with an internal FIFO.
- Sits between a core/cache bus adapter and a RAM port instance.

Parameters:
- ADDR_WIDTH, 17, word address width; must match the RAM.
- DATA_WIDTH, 64, word width in bits.
- BYTE_WIDTH, 8, bits per strobe lane; BYTES_PER_WORD = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 2, RAM read latency in cycles; legal range 1..4.
- FIFO_DEPTH (localparam), READ_LATENCY+2, response FIFO entries.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle if req_valid is also high
- req_addr  in  ADDR_WIDTH  word address
- req_strobe  in  BYTES_PER_WORD  byte write enables; all zero = read
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  DATA_WIDTH  read data; 0 for write responses
- resp_write  out  1  response belongs to a write
- ram_en  out  1  RAM port enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_strobe  out  BYTES_PER_WORD  RAM byte write enables
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid READ_LATENCY cycles after en

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Accept (fire) = req_valid && req_ready.
- RAM drive:
  - ram_en = fire, combinational.
  - ram_addr, ram_strobe and ram_wdata pass req_* through.
  - ram_strobe is 0 when not firing.
- Write vs read: a request is a write iff |req_strobe. Every accepted request, read or write, produces exactly one response.
- In-flight tracking:
  - Shift register of READ_LATENCY stages, each holding {valid, is_write}.
  - Stage 0 loads {fire, is_write} every cycle; stages advance unconditionally and never stall, because the RAM cannot stall.
- FIFO push: when the last stage is valid, push {is_write ? 0 : ram_rdata, is_write} into the FIFO that same cycle.
- Response channel:
  - resp_valid = FIFO non-empty; resp_rdata and resp_write come from the FIFO head.
  - Pop on resp_valid && resp_ready. Push and pop in the same cycle are both honoured.
- Credit rule:
  - req_ready = !reset && (inflight_count + fifo_count) < FIFO_DEPTH.
  - Both counts are registered. There is no combinational path from resp_ready or req_valid to req_ready.
  - The FIFO therefore never overflows; an assertion checks "push && full" is never true.
- Throughput: with resp_ready held high, one request per cycle is sustained indefinitely. First response appears READ_LATENCY+1 cycles after fire, since the FIFO adds one registered cycle.
- Ordering: responses are strictly in request order.
- Reset (any cycle, including mid-operation):
  - All in-flight stages are cleared; outstanding requests are dropped with no response.
  - FIFO is emptied and counts go to 0.
  - During reset: req_ready=0, ram_en=0, resp_valid=0, resp_rdata=0, resp_write=0.
  - req_ready rises in the first cycle after reset deasserts.
- Backpressure: with resp_ready low, at most FIFO_DEPTH requests are accepted, then req_ready drops. It rises again the cycle after the first pop.
- Count width: $clog2(FIFO_DEPTH+1) bits; no wrap. FIFO pointers wrap modulo FIFO_DEPTH (not a power of two in general; explicit compare-and-reset).

Decomposition:
- Shared package ram_pkg holds:
  - ram_req_t {addr, strobe, wdata} and ram_resp_t {rdata, write}, parameterised via package-level defaults matching the RAM defaults;
  - the BYTES_PER_WORD helper constant.
- One sub-module: resp_fifo (synchronous FIFO, parameter DEPTH and WIDTH, sync active-high reset, push/pop/full/empty/count).

Test Plan (READ_LATENCY=2, DATA_WIDTH=64):
1. Write addr 0x10, strobe 0xFF, data 0x1122334455667788; then read 0x10 → write response (resp_write=1, rdata=0) first, then read response rdata=0x1122334455667788. Read response appears 3 cycles after its fire.
2. Partial write strobe 0x0F, data 0xAAAAAAAABBBBBBBB to addr 0x10 (previous value from test 1), then read → 0x11223344BBBBBBBB.
3. Back-to-back reads of addrs 0..7 with resp_ready=1 → req_ready stays 1 for all 8 cycles; 8 consecutive in-order responses with no gaps.
4. resp_ready=0, req_valid=1 continuously → exactly 4 requests accepted, req_ready=0 afterwards. Raise resp_ready for 1 cycle → one pop, then req_ready=1 on the next cycle; no response is lost or duplicated.
5. Reset asserted 1 cycle after 2 reads fire → no responses after reset; resp_valid=0, req_ready=0 during reset, req_ready=1 the cycle after release.
6. Simultaneous push and pop with FIFO at count 2 → count stays 2, head data is correct, and ordering is preserved.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port RAM requester path.
package ram_pkg;

   localparam int RAM_ADDR_WIDTH = 17;
   localparam int RAM_DATA_WIDTH = 64;
   localparam int RAM_BYTE_WIDTH = 8;
   localparam int BYTES_PER_WORD = RAM_DATA_WIDTH / RAM_BYTE_WIDTH;

   typedef struct packed {
      logic [RAM_ADDR_WIDTH-1:0] addr;
      logic [BYTES_PER_WORD-1:0] strobe;
      logic [RAM_DATA_WIDTH-1:0] wdata;
   } ram_req_t;

   typedef struct packed {
      logic [RAM_DATA_WIDTH-1:0] rdata;
      logic                      write;
   } ram_resp_t;

   function automatic int bytes_per_word(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO; depth need not be a power of two, so pointers
// wrap by explicit compare.
module resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Occupancy flags and qualified handshakes.
   always_comb begin
      full      = (count == CNT_W'(DEPTH));
      empty     = (count == '0);
      do_push   = push && !full;
      do_pop    = pop && !empty;
      head_data = mem[rd_ptr];
   end

   // Pointer and count bookkeeping; simultaneous push and pop keeps count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are don't-care while the slot is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ram_port_ctrl.sv
// Requester-side controller for one RAM port: issues requests, tracks the
// fixed read latency and returns one in-order response per request.
module ram_port_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH   = RAM_ADDR_WIDTH,
   parameter int DATA_WIDTH   = RAM_DATA_WIDTH,
   parameter int BYTE_WIDTH   = RAM_BYTE_WIDTH,
   parameter int READ_LATENCY = 2,
   localparam int BPW         = bytes_per_word(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [BPW-1:0]        req_strobe,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_write,
   output logic                  ram_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [BPW-1:0]        ram_strobe,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam int FIFO_DEPTH = READ_LATENCY + 2;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int LAST       = READ_LATENCY - 1;

   logic                    fire;
   logic                    is_write;
   logic [READ_LATENCY-1:0] stage_vld;
   logic [READ_LATENCY-1:0] stage_wr;
   logic                    push_stage;
   logic                    push;
   logic                    pop;
   logic [DATA_WIDTH-1:0]   push_rdata;
   logic [DATA_WIDTH:0]     push_data;
   logic [DATA_WIDTH:0]     head_data;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CNT_W-1:0]        fifo_count;
   logic [CNT_W-1:0]        inflight_count;
   logic [CNT_W:0]          credit_used;

   // Request acceptance from registered credit, RAM drive and response output.
   always_comb begin
      credit_used = {1'b0, inflight_count} + {1'b0, fifo_count};
      req_ready   = !reset && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
      fire        = req_valid && req_ready;
      is_write    = |req_strobe;

      ram_en      = fire;
      ram_addr    = req_addr;
      ram_strobe  = fire ? req_strobe : '0;
      ram_wdata   = req_wdata;

      push_stage  = stage_vld[LAST];
      push        = push_stage && !fifo_full;
      push_rdata  = stage_wr[LAST] ? '0 : ram_rdata;
      push_data   = {push_rdata, stage_wr[LAST]};

      resp_valid  = !fifo_empty && !reset;
      resp_rdata  = resp_valid ? head_data[DATA_WIDTH:1] : '0;
      resp_write  = resp_valid && head_data[0];
      pop         = resp_valid && resp_ready;
   end

   // Latency tracker: advances every cycle because the RAM never stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_vld <= '0;
         stage_wr  <= '0;
      end else begin
         stage_vld[0] <= fire;
         stage_wr[0]  <= fire && is_write;
         for (int i = 1; i < READ_LATENCY; i++) begin
            stage_vld[i] <= stage_vld[i-1];
            stage_wr[i]  <= stage_wr[i-1];
         end
      end
   end

   // Requests issued to the RAM whose data has not yet reached the FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_count <= '0;
      end else begin
         unique case ({fire, push_stage})
            2'b10:   inflight_count <= inflight_count + CNT_W'(1);
            2'b01:   inflight_count <= inflight_count - CNT_W'(1);
            default: inflight_count <= inflight_count;
         endcase
      end
   end

   resp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH + 1)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Credit accounting guarantees a free slot whenever data arrives.
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push_stage && fifo_full));

endmodule
